// File: rtl/riscv_i32_trace_capture.sv
// riscv_i32_trace_capture
// Trace capture controller for the RISC-V i32 trace port. Once armed, it waits
// for a PC-match (or first-valid) trigger. It then records retired instructions
// as {pc, flags} into an internal buffer until the programmed count is reached,
// the buffer fills, or capture is stopped. The buffer is then drained to a
// reader over a valid/ready handshake.
//
// Ports:
//   clk, clk__enable, reset_n    clock, clock enable (low = hold), async active-low reset
//   trace__*                     retired-instruction trace bundle; only pc and flags are kept
//   ctl_arm / ctl_stop           arm pulse (IDLE only) / abort pulse (ARMED, CAPTURE)
//   ctl_trigger_en/_pc           PC-match trigger enable and trigger address
//   ctl_count                    entries to capture; 0 selects the full depth
//   rd_valid/rd_ready            readout handshake; rd_pc/rd_flags hold the entry
//   status_state, status_count   FSM state (0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE), entries held
//
// Optional build macro: RISCV_I32_TRACE_CAPTURE_BRANCH_ONLY_EN. When it is
// defined, capture after the trigger keeps only taken branches and traps.
module riscv_i32_trace_capture #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  clk__enable,
  input  logic                  reset_n,
  input  logic                  trace__instr_valid,
  input  logic [31:0]           trace__instr_pc,
  input  logic [31:0]           trace__instr_data,
  input  logic                  trace__rfw_retire,
  input  logic                  trace__rfw_data_valid,
  input  logic [4:0]            trace__rfw_rd,
  input  logic [31:0]           trace__rfw_data,
  input  logic                  trace__branch_taken,
  input  logic [31:0]           trace__branch_target,
  input  logic                  trace__trap,
  input  logic                  ctl_arm,
  input  logic                  ctl_stop,
  input  logic                  ctl_trigger_en,
  input  logic [31:0]           ctl_trigger_pc,
  input  logic [DEPTH_LOG2:0]   ctl_count,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [31:0]           rd_pc,
  output logic [2:0]            rd_flags,
  output logic [1:0]            status_state,
  output logic [DEPTH_LOG2:0]   status_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned EW    = 35;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d, target_q, target_d, count_inc_c;
  logic [EW-1:0]         mem [DEPTH];
  logic [EW-1:0]         wr_data_c, rd_entry_c;
  logic                  wr_en_c, trigger_c, capture_c, rd_valid_d;
  logic [31:0]           rd_pc_d;
  logic [2:0]            rd_flags_d;
  logic                  unused_c;

  assign unused_c = ^{trace__instr_data, trace__rfw_data_valid, trace__rfw_rd,
                      trace__rfw_data, trace__branch_target};

  assign trigger_c   = trace__instr_valid &&
                       (!ctl_trigger_en || (trace__instr_pc == ctl_trigger_pc));
`ifdef RISCV_I32_TRACE_CAPTURE_BRANCH_ONLY_EN
  assign capture_c   = trace__instr_valid && (trace__branch_taken || trace__trap);
`else
  assign capture_c   = trace__instr_valid;
`endif
  assign wr_data_c   = {trace__instr_pc, trace__trap, trace__branch_taken, trace__rfw_retire};
  assign count_inc_c = count_q + CW'(1);

  // Next-state, buffer-pointer and readout computation
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    target_d   = target_q;
    wr_en_c    = 1'b0;
    rd_valid_d = 1'b0;
    rd_entry_c = '0;
    rd_pc_d    = '0;
    rd_flags_d = '0;

    case (state_q)
      S_IDLE: begin
        if (ctl_arm) begin
          state_d  = S_ARMED;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          // Zero or oversized requests are clamped to the full buffer so it never wraps
          target_d = ((ctl_count == '0) || (ctl_count > CW'(DEPTH))) ? CW'(DEPTH) : ctl_count;
        end
      end
      S_ARMED: begin
        if (trigger_c) begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
          count_d  = count_inc_c;
          state_d  = (count_inc_c == target_q) ? S_DONE : S_CAPTURE;
        end
        if (ctl_stop) state_d = S_DONE;
      end
      S_CAPTURE: begin
        if (capture_c) begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
          count_d  = count_inc_c;
          if (count_inc_c == target_q) state_d = S_DONE;
        end
        if (ctl_stop) state_d = S_DONE;
      end
      S_DONE: begin
        if (count_q == '0) begin
          state_d = S_IDLE;
        end else if (rd_valid && rd_ready) begin
          rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
          count_d  = count_q - CW'(1);
          if (count_q == CW'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered readout; bypass the write port when the final write lands on the head entry
    rd_valid_d = (state_d == S_DONE) && (count_d != '0);
    rd_entry_c = (wr_en_c && (wr_ptr_q == rd_ptr_d)) ? wr_data_c : mem[rd_ptr_d];
    if (rd_valid_d) begin
      rd_pc_d    = rd_entry_c[EW-1:3];
      rd_flags_d = rd_entry_c[2:0];
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      target_q <= '0;
      rd_valid <= 1'b0;
      rd_pc    <= '0;
      rd_flags <= '0;
    end else if (clk__enable) begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      target_q <= target_d;
      rd_valid <= rd_valid_d;
      rd_pc    <= rd_pc_d;
      rd_flags <= rd_flags_d;
    end
  end

  // Capture buffer storage; contents persist until overwritten after the next arm
  always_ff @(posedge clk) begin
    if (clk__enable && wr_en_c) mem[wr_ptr_q] <= wr_data_c;
  end

  assign status_state = state_q;
  assign status_count = count_q;

endmodule

// File: tb/tb_riscv_i32_trace_capture.sv
// Self-checking bench for riscv_i32_trace_capture: scoreboard queue filled as
// instructions are driven, drained by a monitor as the reader accepts entries.
module tb_riscv_i32_trace_capture;

  localparam int unsigned DL = 4;

  logic          clk, clk__enable, reset_n;
  logic          trace__instr_valid;
  logic [31:0]   trace__instr_pc, trace__instr_data;
  logic          trace__rfw_retire, trace__rfw_data_valid;
  logic [4:0]    trace__rfw_rd;
  logic [31:0]   trace__rfw_data;
  logic          trace__branch_taken;
  logic [31:0]   trace__branch_target;
  logic          trace__trap;
  logic          ctl_arm, ctl_stop, ctl_trigger_en;
  logic [31:0]   ctl_trigger_pc;
  logic [DL:0]   ctl_count;
  logic          rd_valid, rd_ready;
  logic [31:0]   rd_pc;
  logic [2:0]    rd_flags;
  logic [1:0]    status_state;
  logic [DL:0]   status_count;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic [34:0] sb_q [$];

  riscv_i32_trace_capture #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .clk__enable(clk__enable), .reset_n(reset_n),
    .trace__instr_valid(trace__instr_valid), .trace__instr_pc(trace__instr_pc),
    .trace__instr_data(trace__instr_data), .trace__rfw_retire(trace__rfw_retire),
    .trace__rfw_data_valid(trace__rfw_data_valid), .trace__rfw_rd(trace__rfw_rd),
    .trace__rfw_data(trace__rfw_data), .trace__branch_taken(trace__branch_taken),
    .trace__branch_target(trace__branch_target), .trace__trap(trace__trap),
    .ctl_arm(ctl_arm), .ctl_stop(ctl_stop), .ctl_trigger_en(ctl_trigger_en),
    .ctl_trigger_pc(ctl_trigger_pc), .ctl_count(ctl_count),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_flags(rd_flags),
    .status_state(status_state), .status_count(status_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard monitor: every accepted entry must match the oldest expected one
  always @(negedge clk) begin
    if (reset_n && clk__enable && rd_valid && rd_ready) begin
      checks++;
      xfers++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL readout_extra: got pc=%h flags=%b, expected no entry", rd_pc, rd_flags);
      end else begin
        logic [34:0] exp_e;
        exp_e = sb_q.pop_front();
        if ({rd_pc, rd_flags} !== exp_e) begin
          errors++;
          $display("FAIL readout_entry: got pc=%h flags=%b, expected pc=%h flags=%b",
                   rd_pc, rd_flags, exp_e[34:3], exp_e[2:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [DL:0] cnt, input logic en, input logic [31:0] tpc);
    ctl_count      = cnt;
    ctl_trigger_en = en;
    ctl_trigger_pc = tpc;
    ctl_arm        = 1'b1;
    tick();
    ctl_arm        = 1'b0;
  endtask

  // Drive one retired instruction for one cycle; push it when it should be stored
  task automatic retire(input logic [31:0] pc, input logic [2:0] fl, input bit store);
    trace__instr_valid  = 1'b1;
    trace__instr_pc     = pc;
    trace__instr_data   = ~pc;
    trace__trap         = fl[2];
    trace__branch_taken = fl[1];
    trace__rfw_retire   = fl[0];
    if (store) sb_q.push_back({pc, fl});
    tick();
    trace__instr_valid  = 1'b0;
    trace__trap         = 1'b0;
    trace__branch_taken = 1'b0;
    trace__rfw_retire   = 1'b0;
  endtask

  task automatic drain(output bit timed_out);
    timed_out = 1'b1;
    rd_ready  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (status_state == 2'd0) begin
        timed_out = 1'b0;
        break;
      end
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (status_state !== 2'd0 || status_count !== '0 || rd_valid !== 1'b0 ||
        rd_pc !== 32'h0 || rd_flags !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: got state=%0d count=%0d valid=%b pc=%h flags=%b, expected 0/0/0/0/0",
               status_state, status_count, rd_valid, rd_pc, rd_flags);
    end
  endtask

  task automatic test_trigger_count();
    bit to;
    int x0;
    arm(5'd4, 1'b1, 32'h100);
    @(negedge clk);
    checks++;
    if (status_state !== 2'd1) begin
      errors++; $display("FAIL arm_state: got %0d, expected 1", status_state);
    end
    retire(32'hF8,  3'b001, 0);
    retire(32'hFC,  3'b010, 0);
    retire(32'h100, 3'b000, 1);
    retire(32'h104, 3'b010, 1);
    retire(32'h108, 3'b001, 1);
    retire(32'h10C, 3'b100, 1);
    @(negedge clk);
    checks++;
    if (status_state !== 2'd3 || status_count !== 5'd4) begin
      errors++;
      $display("FAIL count4_done: got state=%0d count=%0d, expected 3/4", status_state, status_count);
    end
    retire(32'h110, 3'b000, 0);
    @(negedge clk);
    checks++;
    if (status_count !== 5'd4 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL count4_hold: got count=%0d valid=%b, expected 4/1", status_count, rd_valid);
    end
    x0 = xfers;
    drain(to);
    checks++;
    if (to || sb_q.size() != 0 || (xfers - x0) != 4) begin
      errors++;
      $display("FAIL count4_drain: got timeout=%0d left=%0d xfers=%0d, expected 0/0/4",
               to, sb_q.size(), xfers - x0);
    end
  endtask

  task automatic test_count_one();
    bit to;
    arm(5'd1, 1'b1, 32'h40);
    retire(32'h3C, 3'b000, 0);
    retire(32'h40, 3'b011, 1);
    @(negedge clk);
    checks++;
    if (status_state !== 2'd3 || status_count !== 5'd1 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL count1_done: got state=%0d count=%0d valid=%b, expected 3/1/1",
               status_state, status_count, rd_valid);
    end
    retire(32'h44, 3'b000, 0);
    drain(to);
    checks++;
    if (to || sb_q.size() != 0) begin
      errors++; $display("FAIL count1_drain: got timeout=%0d left=%0d, expected 0/0", to, sb_q.size());
    end
  endtask

  task automatic test_full_depth();
    bit to;
    int x0;
    arm(5'd0, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++)
      retire(32'h1000 + 32'(i * 4), 3'(i), i < 16);
    @(negedge clk);
    checks++;
    if (status_state !== 2'd3 || status_count !== 5'd16) begin
      errors++;
      $display("FAIL full_count: got state=%0d count=%0d, expected 3/16", status_state, status_count);
    end
    x0 = xfers;
    drain(to);
    checks++;
    if (to || sb_q.size() != 0 || (xfers - x0) != 16 || status_count !== '0) begin
      errors++;
      $display("FAIL full_drain: got timeout=%0d left=%0d xfers=%0d count=%0d, expected 0/0/16/0",
               to, sb_q.size(), xfers - x0, status_count);
    end
  endtask

  task automatic test_backpressure();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit prev_hold;
    logic [31:0] prev_pc;
    logic [2:0]  prev_fl;
    int x0;
    arm(5'd4, 1'b0, 32'h0);
    retire(32'h2000, 3'b001, 1);
    retire(32'h2004, 3'b010, 1);
    retire(32'h2008, 3'b100, 1);
    retire(32'h200C, 3'b111, 1);
    x0 = xfers;
    prev_hold = 1'b0;
    prev_pc   = '0;
    prev_fl   = '0;
    for (int i = 0; i < 60; i++) begin
      rd_ready = pat[i % 4];
      @(negedge clk);
      if (prev_hold) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_pc !== prev_pc || rd_flags !== prev_fl) begin
          errors++;
          $display("FAIL stall_stable: got valid=%b pc=%h flags=%b, expected 1 pc=%h flags=%b",
                   rd_valid, rd_pc, rd_flags, prev_pc, prev_fl);
        end
      end
      if (status_state == 2'd0) break;
      prev_hold = rd_valid && !rd_ready;
      prev_pc   = rd_pc;
      prev_fl   = rd_flags;
      tick();
    end
    rd_ready = 1'b0;
    checks++;
    if (status_state !== 2'd0 || sb_q.size() != 0 || (xfers - x0) != 4) begin
      errors++;
      $display("FAIL stall_drain: got state=%0d left=%0d xfers=%0d, expected 0/0/4",
               status_state, sb_q.size(), xfers - x0);
    end
  endtask

  task automatic test_stop();
    bit to;
    int x0;
    arm(5'd8, 1'b0, 32'h0);
    retire(32'h3000, 3'b000, 1);
    retire(32'h3004, 3'b010, 1);
    ctl_stop = 1'b1;
    retire(32'h3008, 3'b001, 1);
    ctl_stop = 1'b0;
    arm(5'd2, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (status_state !== 2'd3 || status_count !== 5'd3) begin
      errors++;
      $display("FAIL stop_done: got state=%0d count=%0d, expected 3/3", status_state, status_count);
    end
    x0 = xfers;
    drain(to);
    checks++;
    if (to || sb_q.size() != 0 || (xfers - x0) != 3) begin
      errors++;
      $display("FAIL stop_drain: got timeout=%0d left=%0d xfers=%0d, expected 0/0/3",
               to, sb_q.size(), xfers - x0);
    end
    // Stop while armed with nothing captured: empty DONE, then straight back to IDLE
    arm(5'd4, 1'b1, 32'hDEAD);
    ctl_stop = 1'b1;
    tick();
    ctl_stop = 1'b0;
    @(negedge clk);
    checks++;
    if (status_state !== 2'd3 || rd_valid !== 1'b0 || status_count !== '0) begin
      errors++;
      $display("FAIL stop_armed: got state=%0d valid=%b count=%0d, expected 3/0/0",
               status_state, rd_valid, status_count);
    end
    @(negedge clk);
    checks++;
    if (status_state !== 2'd0) begin
      errors++; $display("FAIL stop_empty_idle: got state=%0d, expected 0", status_state);
    end
  endtask

  task automatic test_async_reset();
    bit to;
    arm(5'd8, 1'b0, 32'h0);
    retire(32'h4000, 3'b000, 0);
    retire(32'h4004, 3'b000, 0);
    retire(32'h4008, 3'b000, 0);
    @(negedge clk);
    checks++;
    if (status_state !== 2'd2 || status_count !== 5'd3) begin
      errors++;
      $display("FAIL pre_reset: got state=%0d count=%0d, expected 2/3", status_state, status_count);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (status_state !== 2'd0 || rd_valid !== 1'b0 || status_count !== '0) begin
      errors++;
      $display("FAIL async_reset: got state=%0d valid=%b count=%0d, expected 0/0/0",
               status_state, rd_valid, status_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    arm(5'd2, 1'b0, 32'h0);
    retire(32'h5000, 3'b100, 1);
    retire(32'h5004, 3'b010, 1);
    @(negedge clk);
    checks++;
    if (status_state !== 2'd3 || status_count !== 5'd2) begin
      errors++;
      $display("FAIL rearm_done: got state=%0d count=%0d, expected 3/2", status_state, status_count);
    end
    drain(to);
    checks++;
    if (to || sb_q.size() != 0) begin
      errors++; $display("FAIL rearm_drain: got timeout=%0d left=%0d, expected 0/0", to, sb_q.size());
    end
  endtask

  task automatic test_branch_filter();
    bit to;
    bit plain_kept;
    logic [DL:0] exp_cnt;
`ifdef RISCV_I32_TRACE_CAPTURE_BRANCH_ONLY_EN
    plain_kept = 1'b0;
    exp_cnt    = 5'd3;
`else
    plain_kept = 1'b1;
    exp_cnt    = 5'd4;
`endif
    arm(5'd4, 1'b1, 32'h200);
    retire(32'h1FC, 3'b010, 0);
    retire(32'h200, 3'b000, 1);
    retire(32'h204, 3'b010, 1);
    retire(32'h208, 3'b001, plain_kept);
    retire(32'h20C, 3'b100, 1);
    ctl_stop = 1'b1;
    tick();
    ctl_stop = 1'b0;
    @(negedge clk);
    checks++;
    if (status_state !== 2'd3 || status_count !== exp_cnt) begin
      errors++;
      $display("FAIL filter_count: got state=%0d count=%0d, expected 3/%0d",
               status_state, status_count, exp_cnt);
    end
    drain(to);
    checks++;
    if (to || sb_q.size() != 0) begin
      errors++; $display("FAIL filter_drain: got timeout=%0d left=%0d, expected 0/0", to, sb_q.size());
    end
  endtask

  initial begin
    reset_n               = 1'b0;
    clk__enable           = 1'b1;
    trace__instr_valid    = 1'b0;
    trace__instr_pc       = '0;
    trace__instr_data     = '0;
    trace__rfw_retire     = 1'b0;
    trace__rfw_data_valid = 1'b0;
    trace__rfw_rd         = '0;
    trace__rfw_data       = '0;
    trace__branch_taken   = 1'b0;
    trace__branch_target  = '0;
    trace__trap           = 1'b0;
    ctl_arm               = 1'b0;
    ctl_stop              = 1'b0;
    ctl_trigger_en        = 1'b0;
    ctl_trigger_pc        = '0;
    ctl_count             = '0;
    rd_ready              = 1'b0;
    #22 reset_n = 1'b1;

    test_reset();
    test_trigger_count();
    test_count_one();
    test_full_depth();
    test_backpressure();
    test_stop();
    test_async_reset();
    test_branch_filter();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
